// File: rtl/pattern_history_table.sv
// Gshare pattern history table: 2^(G_WIDTH+1) two-bit saturating counters with
// a self-initialising sweep after reset. Define PHT_BYPASS_EN to forward a
// same-edge update into the lookup result.
module pattern_history_table #(
  parameter int         G_WIDTH    = 7,
  parameter logic [1:0] INIT_STATE = 2'b01
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             rdEn,
  input  logic [G_WIDTH:0] rdIndex,
  input  logic             wrEn,
  input  logic [G_WIDTH:0] wrIndex,
  input  logic             wrTaken,
  output logic             ready,
  output logic             predValid,
  output logic             predTaken
);

  localparam int DEPTH = 2 ** (G_WIDTH + 1);

  typedef enum logic {
    ST_INIT  = 1'b0,
    ST_READY = 1'b1
  } state_e;

  state_e           state_q, state_d;
  logic [G_WIDTH:0] ptr_q, ptr_d;
  logic             pred_valid_q, pred_valid_d;
  logic             pred_taken_q, pred_taken_d;

  logic [1:0]       table_mem [DEPTH];

  logic             mem_we;
  logic [G_WIDTH:0] mem_waddr;
  logic [1:0]       mem_wdata;
  logic [1:0]       wr_next;
  logic [1:0]       rd_cnt;
  logic             accept_rd;
  logic             accept_wr;

  function automatic logic [1:0] sat_update(input logic [1:0] cnt, input logic taken);
    if (taken) return (cnt == 2'b11) ? cnt : cnt + 2'd1;
    else       return (cnt == 2'b00) ? cnt : cnt - 2'd1;
  endfunction

  assign accept_rd = (state_q == ST_READY) && rdEn;
  assign accept_wr = (state_q == ST_READY) && wrEn;
  assign wr_next   = sat_update(table_mem[wrIndex], wrTaken);

  always_comb begin
    // NOTE: every always_comb output gets a default first so no path infers a latch.
    state_d      = state_q;
    ptr_d        = ptr_q;
    pred_valid_d = accept_rd;
    pred_taken_d = pred_taken_q;
    rd_cnt       = table_mem[rdIndex];
`ifdef PHT_BYPASS_EN
    if (accept_wr && (wrIndex == rdIndex)) rd_cnt = wr_next;
`endif
    if (accept_rd) pred_taken_d = rd_cnt[1];

    unique case (state_q)
      ST_INIT: begin
        ptr_d = ptr_q + 1'b1;
        if (&ptr_q) state_d = ST_READY;
      end
      ST_READY: state_d = ST_READY;
      default:  state_d = ST_INIT;
    endcase
  end

  // Reset gates the write so an update racing a reset assertion is dropped.
  always_comb begin
    mem_we    = 1'b0;
    mem_waddr = wrIndex;
    mem_wdata = wr_next;
    if (reset_n) begin
      if (state_q == ST_INIT) begin
        mem_we    = 1'b1;
        mem_waddr = ptr_q;
        mem_wdata = INIT_STATE;
      end else if (accept_wr) begin
        mem_we = 1'b1;
      end
    end
  end

  // NOTE: the counter array has no reset; the INIT sweep defines its contents,
  // which keeps it mappable to plain RAM.
  always_ff @(posedge clk) begin
    if (mem_we) table_mem[mem_waddr] <= mem_wdata;
  end

  // NOTE: sequential state uses non-blocking assignments only, so every
  // register samples pre-edge values regardless of process ordering.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= ST_INIT;
      ptr_q        <= '0;
      pred_valid_q <= 1'b0;
      pred_taken_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      ptr_q        <= ptr_d;
      pred_valid_q <= pred_valid_d;
      pred_taken_q <= pred_taken_d;
    end
  end

  assign ready     = (state_q == ST_READY);
  assign predValid = pred_valid_q;
  assign predTaken = pred_taken_q;

endmodule

// File: tb/tb_pattern_history_table.sv
// Directed self-checking bench for pattern_history_table at default parameters;
// collision expectation follows the PHT_BYPASS_EN build setting.
module tb_pattern_history_table;

  logic       clk;
  logic       reset_n;
  logic       rdEn;
  logic [7:0] rdIndex;
  logic       wrEn;
  logic [7:0] wrIndex;
  logic       wrTaken;
  logic       ready;
  logic       predValid;
  logic       predTaken;

  int n_vec = 0;
  int n_err = 0;

  pattern_history_table dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .rdEn      (rdEn),
    .rdIndex   (rdIndex),
    .wrEn      (wrEn),
    .wrIndex   (wrIndex),
    .wrTaken   (wrTaken),
    .ready     (ready),
    .predValid (predValid),
    .predTaken (predTaken)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input int obs, input int exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic idle();
    rdEn = 1'b0; wrEn = 1'b0;
  endtask

  task automatic update(input logic [7:0] idx, input logic taken);
    idle();
    wrEn = 1'b1; wrIndex = idx; wrTaken = taken;
    tick();
    idle();
  endtask

  task automatic lookup(input string tag, input logic [7:0] idx, input logic exp);
    idle();
    rdEn = 1'b1; rdIndex = idx;
    tick();
    idle();
    check({tag, "_valid"}, int'(predValid), 1);
    check({tag, "_taken"}, int'(predTaken), int'(exp));
  endtask

  // Counts edges until ready, also counting any predValid seen before it.
  task automatic wait_ready(input string tag);
    int cyc = 0;
    int early_pv = 0;
    while (!ready && cyc < 300) begin
      tick();
      cyc++;
      if (predValid) early_pv++;
    end
    check({tag, "_init_cycles"}, cyc, 256);
    check({tag, "_no_early_pv"}, early_pv, 0);
  endtask

  initial begin
    reset_n = 1'b0; rdIndex = '0; wrIndex = '0; wrTaken = 1'b0;
    idle();
    tick(); tick();
    check("rst_ready", int'(ready), 0);
    check("rst_pv", int'(predValid), 0);
    check("rst_pt", int'(predTaken), 0);

    // Init with lookups and a taken update to 0xFF held throughout.
    rdEn = 1'b1; rdIndex = 8'h5A;
    wrEn = 1'b1; wrIndex = 8'hFF; wrTaken = 1'b1;
    reset_n = 1'b1;
    wait_ready("init");
    idle();
    lookup("first_5a", 8'h5A, 1'b0);
    lookup("ignored_ff", 8'hFF, 1'b0);

    // Saturation on 0x10.
    repeat (3) update(8'h10, 1'b1);
    lookup("sat_up", 8'h10, 1'b1);
    tick();
    check("pv_drop", int'(predValid), 0);
    check("pt_hold", int'(predTaken), 1);
    repeat (4) update(8'h10, 1'b0);
    lookup("sat_down", 8'h10, 1'b0);
    update(8'h10, 1'b1);
    lookup("sat_weak", 8'h10, 1'b0);

    // Same-index collision on 0x22 (counter 01 -> 10).
    rdEn = 1'b1; rdIndex = 8'h22;
    wrEn = 1'b1; wrIndex = 8'h22; wrTaken = 1'b1;
    tick();
    idle();
    check("coll_valid", int'(predValid), 1);
`ifdef PHT_BYPASS_EN
    check("coll_taken", int'(predTaken), 1);
`else
    check("coll_taken", int'(predTaken), 0);
`endif
    lookup("coll_after", 8'h22, 1'b1);

    // Throughput: 0x03 -> 11, 0x05 -> 10; others stay 01.
    update(8'h03, 1'b1);
    update(8'h03, 1'b1);
    update(8'h05, 1'b1);
    for (int i = 0; i < 8; i++) begin
      rdEn = 1'b1; rdIndex = 8'(i);
      wrEn = (i == 1); wrIndex = 8'h40; wrTaken = 1'b1;
      tick();
      check($sformatf("tput%0d_valid", i), int'(predValid), 1);
      check($sformatf("tput%0d_taken", i), int'(predTaken), (i == 3 || i == 5) ? 1 : 0);
    end
    idle();
    tick();
    check("tput_end_pv", int'(predValid), 0);
    lookup("diff_idx_wr", 8'h40, 1'b1);

    // Reset during a lookup on 0x33 (counter 11).
    update(8'h33, 1'b1);
    update(8'h33, 1'b1);
    lookup("pre_rst_33", 8'h33, 1'b1);
    rdEn = 1'b1; rdIndex = 8'h33;
    wrEn = 1'b1; wrIndex = 8'h33; wrTaken = 1'b1;
    reset_n = 1'b0;
    tick();
    check("midrst_pv", int'(predValid), 0);
    check("midrst_ready", int'(ready), 0);
    check("midrst_pt", int'(predTaken), 0);
    idle();
    reset_n = 1'b1;
    wait_ready("reinit");
    lookup("post_rst_33", 8'h33, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
